// File: rtl/vnu_sched.sv
// vnu_sched: variable-node phase scheduler for an LDPC decoder.
// Sequences column reads, VNU enables and message/hard-decision writes
// for each VN pass, hands off to the check-node phase and counts
// decoding iterations up to MAX_ITER.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              begin a codeword (accepted in IDLE only)
//   hold               freeze VN pipeline, counters and state this cycle
//   cn_done            one-cycle pulse: check-node phase finished
//   syndrome_ok        all parity checks satisfied, valid with cn_done
//   rd_en, rd_addr     intrinsic / CNU message RAM read
//   vnu_en             VNU pipeline enable
//   wr_en, wr_addr     VNU Y output write to message RAM
//   hd_we              hard-decision write for wr_addr
//   cn_start           one-cycle pulse launching the CN phase
//   busy, done         status; done is a one-cycle pulse
//   iter_cnt           completed VN passes in this codeword
//
// Build option: define VNU_SCHED_EARLY_TERM_EN to finish as soon as a
// CN phase reports syndrome_ok; hard decisions are then written on
// every VN pass since any pass may turn out to be the last.

module vnu_sched #(
   parameter int N_COLS   = 16,
   parameter int ADDR_W   = 4,
   parameter int MAX_ITER = 8,
   parameter int ITER_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              hold,
   input  logic              cn_done,
   input  logic              syndrome_ok,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              vnu_en,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              hd_we,
   output logic              cn_start,
   output logic              busy,
   output logic              done,
   output logic [ITER_W-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      VN_RUN,
      VN_DRAIN,
      CN_WAIT,
      FINISH
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] col;
   logic [ITER_W-1:0] iter;

   // Read-to-write delay line: valid bit and address per stage.
   // Stage 0 lines up with vnu_en, stage 2 with the write.
   logic [2:0]        dv;
   logic [ADDR_W-1:0] a0;
   logic [ADDR_W-1:0] a1;
   logic [ADDR_W-1:0] a2;

   logic last_col;
   logic dl_empty;
   logic cn_fire;
   logic final_pass;
   logic term;

   assign last_col = (col == ADDR_W'(N_COLS - 1));
   assign dl_empty = (dv == 3'b000);
   assign cn_fire  = (state == VN_DRAIN) && dl_empty && !hold;

`ifdef VNU_SCHED_EARLY_TERM_EN
   assign final_pass = 1'b1;
   assign term       = syndrome_ok || (iter == ITER_W'(MAX_ITER));
`else
   logic unused_synd;
   assign unused_synd = syndrome_ok;
   // iter is bumped only after the drain, so the last pass runs
   // while the count still reads MAX_ITER-1.
   assign final_pass  = (iter == ITER_W'(MAX_ITER - 1));
   assign term        = (iter == ITER_W'(MAX_ITER));
`endif

   // hold must silence the strobes in the same cycle, so they are
   // decoded from registered state and gated here.
   assign rd_en    = (state == VN_RUN) && !hold;
   assign rd_addr  = col;
   assign vnu_en   = dv[0] && !hold;
   assign wr_en    = dv[2] && !hold;
   assign wr_addr  = a2;
   assign hd_we    = wr_en && final_pass;
   assign cn_start = cn_fire;
   assign busy     = (state != IDLE);
   assign done     = (state == FINISH) && !hold;
   assign iter_cnt = iter;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         col   <= '0;
         iter  <= '0;
         dv    <= '0;
         a0    <= '0;
         a1    <= '0;
         a2    <= '0;
      end else begin
         if (!hold) begin
            dv <= {dv[1:0], rd_en};
            a0 <= col;
            a1 <= a0;
            a2 <= a1;
         end
         case (state)
            IDLE: begin
               if (start && !hold) begin
                  state <= VN_RUN;
                  col   <= '0;
                  iter  <= '0;
               end
            end
            VN_RUN: begin
               if (!hold) begin
                  if (last_col) begin
                     col   <= '0;
                     state <= VN_DRAIN;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            VN_DRAIN: begin
               if (cn_fire) begin
                  iter  <= iter + 1'b1;
                  state <= CN_WAIT;
               end
            end
            // cn_done is a one-shot pulse from another controller,
            // so it is taken even while hold is asserted.
            CN_WAIT: begin
               if (cn_done) begin
                  if (term) begin
                     state <= FINISH;
                  end else begin
                     state <= VN_RUN;
                     col   <= '0;
                  end
               end
            end
            FINISH: begin
               if (!hold) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vnu_sched.sv
// tb_vnu_sched: randomized self-checking bench for vnu_sched.
// Checks read/write ordering, latency in enabled cycles and status.

module tb_vnu_sched;

   localparam int N  = 16;
   localparam int AW = 4;
   localparam int MI = 2;
   localparam int IW = 4;
`ifdef VNU_SCHED_EARLY_TERM_EN
   localparam bit ET = 1'b1;
`else
   localparam bit ET = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          hold = 1'b0;
   logic          cn_done = 1'b0;
   logic          syndrome_ok = 1'b0;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          vnu_en;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          hd_we;
   logic          cn_start;
   logic          busy;
   logic          done;
   logic [IW-1:0] iter_cnt;

   int checks = 0;
   int failures = 0;

   vnu_sched #(
      .N_COLS(N), .ADDR_W(AW), .MAX_ITER(MI), .ITER_W(IW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .hold(hold),
      .cn_done(cn_done), .syndrome_ok(syndrome_ok),
      .rd_en(rd_en), .rd_addr(rd_addr), .vnu_en(vnu_en),
      .wr_en(wr_en), .wr_addr(wr_addr), .hd_we(hd_we),
      .cn_start(cn_start), .busy(busy), .done(done),
      .iter_cnt(iter_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: every read at enabled cycle u must reach the VNU
   // at enabled cycle u+1 and be written (same address) at u+3.
   int ucyc = 0;
   int rd_log[$];
   int wr_log[$];
   bit hd_log[$];
   int vn_t[$];
   int wr_t[$];
   int wr_a[$];
   int lat_bad = 0;
   int hold_bad = 0;
   int n_cn = 0;
   int n_done = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (!hold) ucyc++;
         if (hold && (rd_en || vnu_en || wr_en || hd_we)) hold_bad++;
         if (rd_en) begin
            rd_log.push_back(int'(rd_addr));
            vn_t.push_back(ucyc + 1);
            wr_t.push_back(ucyc + 3);
            wr_a.push_back(int'(rd_addr));
         end
         if (vnu_en) begin
            if (vn_t.size() == 0 || vn_t[0] != ucyc) lat_bad++;
            if (vn_t.size() != 0) void'(vn_t.pop_front());
         end
         if (wr_en) begin
            wr_log.push_back(int'(wr_addr));
            hd_log.push_back(hd_we);
            if (wr_t.size() == 0) lat_bad++;
            else begin
               if (wr_t[0] != ucyc || wr_a[0] != int'(wr_addr)) lat_bad++;
               void'(wr_t.pop_front());
               void'(wr_a.pop_front());
            end
         end
         if (!wr_en && hd_we) lat_bad++;
         if (cn_start) n_cn++;
         if (done) n_done++;
      end
   end

   function automatic int seq_errs(int passes);
      int e = 0;
      if (rd_log.size() != N * passes) return 1000 + rd_log.size();
      if (wr_log.size() != N * passes) return 2000 + wr_log.size();
      for (int i = 0; i < N * passes; i++) begin
         if (rd_log[i] != i % N) e++;
         if (wr_log[i] != i % N) e++;
      end
      return e;
   endfunction

   function automatic int hd_errs(int passes);
      int e = 0;
      bit exp_hd;
      if (hd_log.size() != N * passes) return 1000 + hd_log.size();
      for (int i = 0; i < N * passes; i++) begin
         exp_hd = ET || (i / N == passes - 1);
         if (hd_log[i] != exp_hd) e++;
      end
      return e;
   endfunction

   int h7_addr;
   int h7_n;

   // Stimulus driver for one codeword. cn_dly=0 picks random CN latency.
   task automatic run_decode(input int hold_pct, input int cn_dly,
                             input bit synd, input bit spur,
                             input bit hold7, output bit fin);
      int cd = 0;
      int hc = 0;
      int tmo = 0;
      bit h7_used = 0;
      bit sp_cn;
      fin = 0;
      rd_log.delete(); wr_log.delete(); hd_log.delete();
      vn_t.delete(); wr_t.delete(); wr_a.delete();
      lat_bad = 0; hold_bad = 0; n_cn = 0; n_done = 0;
      h7_addr = -1; h7_n = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      while (!fin && tmo < 5000) begin
         @(negedge clk);
         tmo++;
         if (cn_start) cd = (cn_dly > 0) ? cn_dly : int'($urandom_range(6, 1));
         if (done) fin = 1;
         if (hold && hold7) begin h7_addr = int'(rd_addr); h7_n++; end
         if (hold7 && !h7_used && rd_en && rd_addr == 7) begin
            hc = 3; h7_used = 1;
         end
         sp_cn = spur && rd_en && rd_addr == 3;
         @(posedge clk); #1;
         cn_done = 1'b0; start = 1'b0; syndrome_ok = 1'b0;
         if (hc > 0) begin hold = 1'b1; hc--; end
         else hold = ($urandom_range(99, 0) < hold_pct);
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin cn_done = 1'b1; syndrome_ok = synd; end
            else if (spur && cd == 2) start = 1'b1;
         end
         if (sp_cn) cn_done = 1'b1;
      end
      hold = 1'b0; cn_done = 1'b0; start = 1'b0; syndrome_ok = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({rd_en, vnu_en, wr_en, hd_we, cn_start, done} !== 6'b0) begin
         failures++;
         $display("FAIL reset_strobes: got %b want 000000",
                  {rd_en, vnu_en, wr_en, hd_we, cn_start, done});
      end
      checks++;
      if (busy !== 1'b0 || iter_cnt !== '0) begin
         failures++;
         $display("FAIL reset_status: busy=%b iter=%0d want 0/0", busy, iter_cnt);
      end
      checks++;
      if (rd_addr !== '0 || wr_addr !== '0) begin
         failures++;
         $display("FAIL reset_addr: rd=%0d wr=%0d want 0/0", rd_addr, wr_addr);
      end
      rst = 1'b0;
   endtask

   task automatic test_nominal;
      bit fin;
      int e;
      run_decode(0, 4, 1'b0, 1'b0, 1'b0, fin);
      checks++;
      if (fin !== 1'b1) begin failures++; $display("FAIL nom_timeout: done never seen"); end
      e = seq_errs(MI);
      checks++;
      if (e !== 0) begin failures++; $display("FAIL nom_seq: errs=%0d want 0", e); end
      e = hd_errs(MI);
      checks++;
      if (e !== 0) begin failures++; $display("FAIL nom_hd: errs=%0d want 0", e); end
      checks++;
      if (lat_bad !== 0) begin failures++; $display("FAIL nom_latency: bad=%0d want 0", lat_bad); end
      checks++;
      if (n_cn !== MI || n_done !== 1) begin
         failures++;
         $display("FAIL nom_pulses: cn_start=%0d done=%0d want %0d/1", n_cn, n_done, MI);
      end
      checks++;
      if (busy !== 1'b0 || int'(iter_cnt) !== MI) begin
         failures++;
         $display("FAIL nom_end: busy=%b iter=%0d want 0/%0d", busy, iter_cnt, MI);
      end
   endtask

   task automatic test_hold_at7;
      bit fin;
      int e;
      run_decode(0, 4, 1'b0, 1'b0, 1'b1, fin);
      checks++;
      if (fin !== 1'b1) begin failures++; $display("FAIL hold7_timeout: done never seen"); end
      checks++;
      if (h7_n !== 3 || h7_addr !== 8) begin
         failures++;
         $display("FAIL hold7_frozen: cycles=%0d addr=%0d want 3/8", h7_n, h7_addr);
      end
      checks++;
      if (hold_bad !== 0) begin failures++; $display("FAIL hold7_strobes: bad=%0d want 0", hold_bad); end
      e = seq_errs(MI);
      checks++;
      if (e !== 0) begin failures++; $display("FAIL hold7_seq: errs=%0d want 0", e); end
      checks++;
      if (lat_bad !== 0) begin failures++; $display("FAIL hold7_latency: bad=%0d want 0", lat_bad); end
   endtask

   task automatic test_random_hold;
      bit fin;
      int e;
      for (int r = 0; r < 3; r++) begin
         run_decode(30, 0, 1'b0, 1'b1, 1'b0, fin);
         checks++;
         if (fin !== 1'b1) begin failures++; $display("FAIL rnd%0d_timeout: done never seen", r); end
         e = seq_errs(MI);
         checks++;
         if (e !== 0) begin failures++; $display("FAIL rnd%0d_seq: errs=%0d want 0", r, e); end
         e = hd_errs(MI);
         checks++;
         if (e !== 0) begin failures++; $display("FAIL rnd%0d_hd: errs=%0d want 0", r, e); end
         checks++;
         if (lat_bad !== 0 || hold_bad !== 0) begin
            failures++;
            $display("FAIL rnd%0d_timing: lat=%0d hold=%0d want 0/0", r, lat_bad, hold_bad);
         end
         checks++;
         if (n_cn !== MI || n_done !== 1 || int'(iter_cnt) !== MI) begin
            failures++;
            $display("FAIL rnd%0d_counts: cn=%0d done=%0d iter=%0d want %0d/1/%0d",
                     r, n_cn, n_done, iter_cnt, MI, MI);
         end
      end
   endtask

   task automatic test_reset_mid;
      bit found = 0;
      int w0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clk);
         if (rd_en && rd_addr == 5) found = 1;
      end
      checks++;
      if (found !== 1'b1) begin failures++; $display("FAIL rstmid_addr5: never reached"); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({rd_en, vnu_en, wr_en, hd_we, cn_start, done, busy} !== 7'b0) begin
         failures++;
         $display("FAIL rstmid_outputs: got %b want 0000000",
                  {rd_en, vnu_en, wr_en, hd_we, cn_start, done, busy});
      end
      checks++;
      if (rd_addr !== '0 || wr_addr !== '0 || iter_cnt !== '0) begin
         failures++;
         $display("FAIL rstmid_values: rd=%0d wr=%0d iter=%0d want 0", rd_addr, wr_addr, iter_cnt);
      end
      @(posedge clk); #1 rst = 1'b0;
      w0 = wr_log.size();
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (wr_log.size() !== w0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_after: writes=%0d busy=%b want 0/0", wr_log.size() - w0, busy);
      end
   endtask

   task automatic test_early_term;
      bit fin;
      int e;
      int passes;
      passes = ET ? 1 : MI;
      run_decode(0, 4, 1'b1, 1'b0, 1'b0, fin);
      checks++;
      if (fin !== 1'b1) begin failures++; $display("FAIL et_timeout: done never seen"); end
      checks++;
      if (int'(iter_cnt) !== passes || n_cn !== passes || n_done !== 1) begin
         failures++;
         $display("FAIL et_iters: iter=%0d cn=%0d done=%0d want %0d/%0d/1",
                  iter_cnt, n_cn, n_done, passes, passes);
      end
      e = seq_errs(passes);
      checks++;
      if (e !== 0) begin failures++; $display("FAIL et_seq: errs=%0d want 0", e); end
      e = hd_errs(passes);
      checks++;
      if (e !== 0) begin failures++; $display("FAIL et_hd: errs=%0d want 0", e); end
   endtask

   initial begin
      test_reset;
      test_nominal;
      test_hold_at7;
      test_random_hold;
      test_reset_mid;
      test_early_term;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vnu_sched.md
VNU_SCHED -- requirements
Module: vnu_sched

Interface
REQ-001 The block SHALL have parameter N_COLS, default 16: number of variable-node columns processed per VN phase (>=2).
REQ-002 The block SHALL have parameter ADDR_W, default 4: column address width, at least clog2(N_COLS).
REQ-003 The block SHALL have parameter MAX_ITER, default 8: decoding iterations per codeword (>=1).
REQ-004 The block SHALL have parameter ITER_W, default 4: iteration counter width, at least clog2(MAX_ITER+1).
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: begin decoding a codeword; sampled in IDLE only.
REQ-008 The block SHALL have port hold, input, 1 bit: freeze the VN pipeline and all counters for the cycle.
REQ-009 The block SHALL have port cn_done, input, 1 bit: one-cycle pulse from the check-node phase controller.
REQ-010 The block SHALL have port syndrome_ok, input, 1 bit: all parity checks satisfied, valid with cn_done.
REQ-011 The block SHALL have port rd_en / rd_addr, output, 1 / ADDR_W bits: read of intrinsic RAM and CNU message RAM.
REQ-012 The block SHALL have port vnu_en, output, 1 bit: VNU pipeline enable.
REQ-013 The block SHALL have port wr_en / wr_addr, output, 1 / ADDR_W bits: write of VNU Y outputs to message RAM.
REQ-014 The block SHALL have port hd_we, output, 1 bit: write of hard_decision for wr_addr.
REQ-015 The block SHALL have port cn_start, output, 1 bit: one-cycle pulse that launches the CN phase.
REQ-016 The block SHALL have ports busy, done, iter_cnt, output, 1 / 1 / ITER_W bits: status; done is a one-cycle pulse.

Function
REQ-017 The FSM SHALL have states IDLE, VN_RUN, VN_DRAIN, CN_WAIT and FINISH.
REQ-018 IDLE SHALL go to VN_RUN on start=1, with iter_cnt=0 and column counter=0.
REQ-019 VN_RUN SHALL assert rd_en with rd_addr=column counter on each non-hold cycle, increment the counter, and go to VN_DRAIN after issuing address N_COLS-1.
REQ-020 Read data SHALL be valid one cycle after rd_en, so vnu_en SHALL equal the non-held rd_en delayed by one.
REQ-021 Y SHALL be valid two enabled VNU cycles later, so wr_en/wr_addr SHALL track rd_en/rd_addr through a 3-stage delay line that advances only when hold=0.
REQ-022 While hold=1: rd_en=0, vnu_en=0, wr_en=0, hd_we=0; counters, state and delay line SHALL be unchanged; no address SHALL be skipped or duplicated.
REQ-023 VN_DRAIN SHALL remain until the delay line is empty, then increment iter_cnt, pulse cn_start for one cycle and go to CN_WAIT.
REQ-024 CN_WAIT SHALL go to FINISH on cn_done when iter_cnt==MAX_ITER, otherwise back to VN_RUN with column counter=0.
REQ-025 hd_we SHALL equal wr_en during the VN pass whose completion makes iter_cnt==MAX_ITER, and SHALL be 0 otherwise.
REQ-026 FINISH SHALL pulse done for one cycle and return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-027 start outside IDLE and cn_done outside CN_WAIT SHALL be ignored; a cn_done together with hold SHALL still be honoured.
REQ-028 Each VN pass SHALL issue exactly N_COLS reads and N_COLS writes, ascending from address 0.

Reset
REQ-029 rst SHALL immediately force IDLE and clear the column counter, iter_cnt and delay line, and drive all outputs to 0, including in the middle of a pass; no write SHALL follow reset.

Configuration
REQ-030 When VNU_SCHED_EARLY_TERM_EN is defined, cn_done with syndrome_ok=1 SHALL go to FINISH regardless of iter_cnt, and the final VN pass SHALL be the one preceding that CN phase, so hd_we SHALL assert on every VN pass.
REQ-031 When VNU_SCHED_EARLY_TERM_EN is undefined, syndrome_ok SHALL be ignored and exactly MAX_ITER iterations SHALL always run.

Verification
REQ-032 rst during VN_RUN at address 5 -> all outputs 0 the same cycle; IDLE after release; no wr_en.
REQ-033 N_COLS=16, MAX_ITER=2, start, no hold, cn_done 4 cycles after each cn_start -> rd_addr 0..15, wr_addr 0..15 three cycles later, 2 cn_start pulses, hd_we on the second pass only, one done pulse, iter_cnt=2.
REQ-034 hold=1 for 3 cycles after rd_addr=7 -> outputs frozen, then rd_addr resumes at 8 and wr_addr sequence stays gapless 0..15.
REQ-035 start pulsed during CN_WAIT and spurious cn_done during VN_RUN -> no state change, counts unaffected.
REQ-036 Macro defined, MAX_ITER=8, syndrome_ok=1 at the first cn_done -> FINISH after 1 iteration, iter_cnt=1, done pulse; macro undefined -> 8 iterations.
